ehl_clk_div: RTL and testbench



---
 rtl/ehl_clk_div.sv | 114 +++++++++++
 tb/tb_ehl_clk_div.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ehl_clk_div.sv
// ehl_clk_div: programmable synchronous clock divider feeding a clock buffer.
//   Divides clk by a runtime ratio N (2..2^WIDTH-1). The divider starts and
//   stops glitch-free. Ratio updates go through a shadow register and take
//   effect only on a period boundary.
// Ports:
//   clk        root clock, rising edge
//   reset_n    synchronous active-low reset
//   enable_i   level: 1 runs, 0 requests a stop at the end of the period
//   div_i      requested ratio (0 and 1 are clamped to 2)
//   div_load_i strobe: capture div_i into the shadow register
//   div_ack_o  pulse: the shadow ratio became active
//   clk_o      divided clock (flop output)
//   period_o   pulse coincident with each rising edge of clk_o
//   running_o  divider is in RUN
module ehl_clk_div #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic             clk_o,
  output logic             period_o,
  output logic             running_o
);

  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] n_act, n_nxt, shadow, shadow_nxt, div_clamped;
  logic [WIDTH:0]   half;
  logic             pending, pending_nxt, apply, wrap;
  logic             clk_nxt, period_nxt;

  assign div_clamped = (div_i < WIDTH'(2)) ? WIDTH'(2) : div_i;
  // High phase length is ceil(N/2). One extra bit keeps N+1 from overflowing.
  assign half        = ({1'b0, n_act} + 1'b1) >> 1;
  assign cnt_inc     = cnt + 1'b1;
  assign wrap        = (state == RUN) && (cnt == n_act - 1'b1);

  // Outputs are registered from next-state values. clk_o therefore reflects
  // the counter position it will hold during the coming cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clk_nxt    = 1'b0;
    period_nxt = 1'b0;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        apply   = pending;
        if (enable_i) begin
          state_nxt  = RUN;
          clk_nxt    = 1'b1;
          period_nxt = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_nxt = '0;
          apply   = pending;
          // Stop only at the end of a period, so no runt pulse is produced.
          if (enable_i) begin
            clk_nxt    = 1'b1;
            period_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_inc;
          clk_nxt = ({1'b0, cnt_inc} < half);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A load on the apply edge stays pending. The older shadow value is the
    // one that gets applied.
    n_nxt       = apply ? shadow : n_act;
    shadow_nxt  = div_load_i ? div_clamped : shadow;
    pending_nxt = div_load_i | (pending & ~apply);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      n_act     <= DEF_N;
      shadow    <= DEF_N;
      pending   <= 1'b0;
      clk_o     <= 1'b0;
      period_o  <= 1'b0;
      div_ack_o <= 1'b0;
      running_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      n_act     <= n_nxt;
      shadow    <= shadow_nxt;
      pending   <= pending_nxt;
      clk_o     <= clk_nxt;
      period_o  <= period_nxt;
      div_ack_o <= apply;
      running_o <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_ehl_clk_div.sv
// Directed bench for ehl_clk_div. All outputs are sampled 1 time unit after
// each rising edge as obs = {clk_o, period_o, running_o, div_ack_o}.
module tb_ehl_clk_div;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable_i = 1'b0;
  logic [7:0] div_i = '0;
  logic       div_load_i = 1'b0;
  logic       div_ack_o, clk_o, period_o, running_o;
  logic [3:0] obs;
  int         vectors = 0;
  int         miscompares = 0;

  ehl_clk_div #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .div_i(div_i),
    .div_load_i(div_load_i), .div_ack_o(div_ack_o), .clk_o(clk_o),
    .period_o(period_o), .running_o(running_o)
  );

  always #5 clk = ~clk;
  assign obs = {clk_o, period_o, running_o, div_ack_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then run at N=4 for 20 periods. The test ends at cnt=0, not yet checked.
  task automatic test_reset_default();
    logic [3:0] exp4 [4] = '{4'b1110, 4'b1010, 4'b0010, 4'b0010};
    tick();
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++; $display("FAIL reset: got %b want %b", obs, 4'b0000);
    end
    reset_n = 1'b1; enable_i = 1'b1;
    tick();
    for (int p = 0; p < 20; p++)
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (obs !== exp4[j]) begin
          miscompares++;
          $display("FAIL default_n4 p%0d c%0d: got %b want %b", p, j, obs, exp4[j]);
        end
        tick();
      end
  endtask

  // Load 5 at cnt=1. The current period stays 4 cycles, the ack comes on the wrap, then 3 high / 2 low.
  task automatic test_ratio_update();
    logic [3:0] exp_a [4] = '{4'b1010, 4'b0010, 4'b0010, 4'b1111};
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin div_load_i = 1'b1; div_i = 8'd5; end
      else div_load_i = 1'b0;
      vectors++;
      if (obs !== exp_a[i]) begin
        miscompares++; $display("FAIL update_n5 step%0d: got %b want %b", i, obs, exp_a[i]);
      end
    end
    for (int i = 1; i < 10; i++) begin
      tick();
      e = {(i % 5) < 3, (i % 5) == 0, 1'b1, 1'b0};
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("FAIL run_n5 i%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  // Switch to N=6, drop enable_i at cnt=1. The period completes, then IDLE.
  task automatic test_stop();
    logic [3:0] e;
    div_load_i = 1'b1; div_i = 8'd6;       // coincides with the N=5 wrap edge
    for (int i = 0; i < 6; i++) begin
      tick();
      div_load_i = 1'b0;
      e = (i == 5) ? 4'b1111 : {i < 3, i == 0, 1'b1, 1'b0};
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("FAIL to_n6 i%0d: got %b want %b", i, obs, e);
      end
    end
    tick();
    vectors++;
    if (obs !== 4'b1010) begin
      miscompares++; $display("FAIL n6_cnt1: got %b want %b", obs, 4'b1010);
    end
    enable_i = 1'b0;
    for (int c = 2; c < 10; c++) begin
      tick();
      e = (c <= 5) ? {c < 3, 1'b0, 1'b1, 1'b0} : 4'b0000;
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("FAIL stop c%0d: got %b want %b", c, obs, e);
      end
    end
  endtask

  // Loads of 0 and 1 in IDLE clamp to 2 and are acked 1 cycle later.
  task automatic test_clamp();
    logic [3:0] exp_l [3] = '{4'b0000, 4'b0001, 4'b0000};
    logic [3:0] e;
    for (int k = 0; k < 2; k++) begin
      div_load_i = 1'b1; div_i = 8'(k);
      for (int i = 0; i < 3; i++) begin
        tick();
        div_load_i = 1'b0;
        vectors++;
        if (obs !== exp_l[i]) begin
          miscompares++; $display("FAIL clamp_load%0d s%0d: got %b want %b", k, i, obs, exp_l[i]);
        end
      end
    end
    enable_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      e = {i % 2 == 0, i % 2 == 0, 1'b1, 1'b0};
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("FAIL clamp_run_n2 i%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  // Move to N=7 and leave a pending load of 9. Reset mid-high. Then N=4 with no ack.
  task automatic test_reset_mid();
    logic [3:0] exp_s [4] = '{4'b0010, 4'b1111, 4'b1010, 4'b1010};
    logic [3:0] e;
    div_load_i = 1'b1; div_i = 8'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      div_load_i = (i == 1);
      if (i == 1) div_i = 8'd9;
      vectors++;
      if (obs !== exp_s[i]) begin
        miscompares++; $display("FAIL pre_reset s%0d: got %b want %b", i, obs, exp_s[i]);
      end
    end
    reset_n = 1'b0; enable_i = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++; $display("FAIL post_reset s%0d: got %b want %b", i, obs, 4'b0000);
      end
      tick();
    end
    enable_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = {(i % 4) < 2, (i % 4) == 0, 1'b1, 1'b0};
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("FAIL reset_n4 i%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  // Go to N=8, then load 9 and 3 in one period: one ack, and the next period is N=3.
  task automatic test_back_to_back();
    logic [3:0] exp_t [17] = '{
      4'b1110, 4'b1010, 4'b0010, 4'b0010, 4'b1111,      // N=4 -> 8
      4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010,      // N=8 cnt1..5
      4'b0010, 4'b0010, 4'b1111,                        // cnt6,7, wrap to N=3
      4'b1010, 4'b0010, 4'b1110, 4'b1010};              // N=3 waveform
    div_load_i = 1'b1; div_i = 8'd8;       // coincides with the N=4 wrap edge
    for (int i = 0; i < 17; i++) begin
      tick();
      div_load_i = (i == 5) || (i == 7);
      div_i = (i == 5) ? 8'd9 : 8'd3;
      vectors++;
      if (obs !== exp_t[i]) begin
        miscompares++; $display("FAIL back_to_back s%0d: got %b want %b", i, obs, exp_t[i]);
      end
    end
  endtask

  initial begin
    test_reset_default();
    test_ratio_update();
    test_stop();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
